// File: rtl/dma_arb_pkg.sv
// dma_arb_pkg: shared state/mode types and mode-field extraction for the DMA channel arbiter
package dma_arb_pkg;
    typedef enum logic [1:0] {IDLE, HOLD_REQ, SERVICE, RELEASE} state_e;
    typedef enum logic [1:0] {MODE_DEMAND = 2'b00, MODE_SINGLE = 2'b01, MODE_BLOCK = 2'b10} mode_e;
    localparam int MAX_CH = 8;
    // The reserved encoding 2'b11 behaves as single-transfer mode
    function automatic mode_e ch_mode(input logic [2*MAX_CH-1:0] modes, input logic [2:0] ch);
        logic [1:0] m;
        m = modes[{ch, 1'b0} +: 2];
        return (m == 2'b11) ? MODE_SINGLE : mode_e'(m);
    endfunction
endpackage

// File: rtl/dma_priority_encoder.sv
// dma_priority_encoder: first requesting channel at or after ptr_i, wrapping modulo NUM_CH
module dma_priority_encoder #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [CH_W-1:0]   win_o,
    output logic              valid_o
);
    logic [CH_W-1:0] idx;
    always_comb begin
        idx   = '0;
        win_o = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = CH_W'((int'(ptr_i) + k) % NUM_CH);
            if (req_i[idx]) win_o = idx;
        end
    end
    assign valid_o = |req_i;
endmodule

// File: rtl/dma_channel_arbiter.sv
// dma_channel_arbiter: Dreq/Hrq/Hlda/Dack handshake with masking and fixed or rotating priority
module dma_channel_arbiter
    import dma_arb_pkg::*;
#(
    parameter int NUM_CH           = 4,
    parameter int CH_W             = $clog2(NUM_CH),
    parameter bit DREQ_ACTIVE_HIGH = 1'b1,
    parameter bit DACK_ACTIVE_HIGH = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_CH-1:0]   dreq_i,
    input  logic [NUM_CH-1:0]   mask_i,
    input  logic [2*NUM_CH-1:0] ch_mode_i,
    input  logic                rot_pri_i,
    input  logic                hlda_i,
    input  logic                xfer_done_i,
    input  logic                eop_i,
    output logic                hrq_o,
    output logic [NUM_CH-1:0]   dack_o,
    output logic                active_o,
    output logic [CH_W-1:0]     active_ch_o,
    output logic                abort_err_o
);
    localparam logic [NUM_CH-1:0] DACK_IDLE = DACK_ACTIVE_HIGH ? '0 : '1;
    state_e            state_q, state_d;
    logic              hrq_q, hrq_d, active_q, active_d, abort_q, abort_d;
    logic [NUM_CH-1:0] dack_q, dack_d, req, onehot;
    logic [CH_W-1:0]   ch_q, ch_d, ptr_q, ptr_d, win, next_ptr;
    logic              win_valid, end_evt;
    logic [15:0]       modes;
    mode_e             mode;

    assign req      = (DREQ_ACTIVE_HIGH ? dreq_i : ~dreq_i) & ~mask_i;
    assign modes    = 16'(ch_mode_i);
    assign mode     = ch_mode(modes, 3'(ch_q));
    assign onehot   = NUM_CH'(1) << win;
    assign next_ptr = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
    // A masked active channel finishes on its next transfer whatever its mode
    assign end_evt  = eop_i | (xfer_done_i & (mask_i[ch_q] | mode == MODE_SINGLE |
                      (mode == MODE_DEMAND & ~req[ch_q])));

    dma_priority_encoder #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_prio (
        .req_i   (req),
        .ptr_i   (rot_pri_i ? ptr_q : '0),
        .win_o   (win),
        .valid_o (win_valid)
    );

    always_comb begin
        state_d  = state_q;
        hrq_d    = hrq_q;
        dack_d   = dack_q;
        active_d = active_q;
        ch_d     = ch_q;
        ptr_d    = ptr_q;
        abort_d  = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = win_valid ? HOLD_REQ : IDLE;
                hrq_d   = win_valid;
            end
            HOLD_REQ: begin
                if (hlda_i && win_valid) begin
                    state_d  = SERVICE;
                    dack_d   = DACK_ACTIVE_HIGH ? onehot : ~onehot;
                    active_d = 1'b1;
                    ch_d     = win;
                end else if (hlda_i || !win_valid) begin
                    state_d = hlda_i ? RELEASE : IDLE;
                    hrq_d   = 1'b0;
                end
            end
            SERVICE: begin
                // Losing Hlda aborts without advancing the rotation
                if (!hlda_i || end_evt) begin
                    state_d  = hlda_i ? RELEASE : IDLE;
                    hrq_d    = 1'b0;
                    dack_d   = DACK_IDLE;
                    active_d = 1'b0;
                    abort_d  = !hlda_i;
                    ptr_d    = hlda_i ? next_ptr : ptr_q;
                end
            end
            default: state_d = hlda_i ? RELEASE : IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            hrq_q    <= 1'b0;
            dack_q   <= DACK_IDLE;
            active_q <= 1'b0;
            ch_q     <= '0;
            ptr_q    <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hrq_q    <= hrq_d;
            dack_q   <= dack_d;
            active_q <= active_d;
            ch_q     <= ch_d;
            ptr_q    <= ptr_d;
            abort_q  <= abort_d;
        end
    end

    assign hrq_o       = hrq_q;
    assign dack_o      = dack_q;
    assign active_o    = active_q;
    assign active_ch_o = ch_q;
    assign abort_err_o = abort_q;
endmodule
